imm_ext_sched: RTL and testbench

Scheduler that shares one 16-to-32-bit immediate extender between two requesters (decode stage = port 0, branch/address unit = port 1). Arbitrates round-robin, latches the winning operand and mode, performs sign or zero extension in a registered stage, and returns the result with a valid/ready handshake tagged by requester ID. Sits between the requesters and the downstream datapath consumer of `BusImm`.

---
 rtl/imm_ext_sched.sv | 117 +++++++++++
 tb/tb_imm_ext_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_sched.sv
// Shares one immediate extender between two requesters. Arbitration is round-robin and the result is registered.
// A result appears 2 edges after the request. The held result stalls new grants until Ready. Optional feature: IMM_EXT_LUI_EN.
module imm_ext_sched #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [IMM_W-1:0] Imm0,
  input  logic [IMM_W-1:0] Imm1,
  input  logic             Ctrl0,
  input  logic             Ctrl1,
  input  logic             Lui0,
  input  logic             Lui1,
  output logic             Ack0,
  output logic             Ack1,
  output logic [OUT_W-1:0] BusImm,
  output logic             Valid,
  output logic             Id,
  input  logic             Ready,
  output logic             Busy
);

  localparam int PAD = OUT_W - IMM_W;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXT  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             pri;
  logic [IMM_W-1:0] lat_imm;
  logic             lat_ctrl;
  logic             lat_id;
  logic             arb_pri;
  logic             win;
  logic             do_grant;
  logic [OUT_W-1:0] ext;

  // On a handshake the pointer update and the new arbitration happen on the same edge.
  assign arb_pri  = (state == RESP) ? ~Id : pri;
  assign win      = (Req0 && Req1) ? arb_pri : Req1;
  assign do_grant = (Req0 || Req1) && ((state == IDLE) || ((state == RESP) && Ready));

`ifdef IMM_EXT_LUI_EN
  logic lat_lui;

  always_comb begin
    ext = lat_ctrl ? {{PAD{1'b0}}, lat_imm} : {{PAD{lat_imm[IMM_W-1]}}, lat_imm};
    if (lat_lui) ext = {lat_imm, {PAD{1'b0}}};
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L)      lat_lui <= 1'b0;
    else if (do_grant) lat_lui <= win ? Lui1 : Lui0;
  end
`else
  logic unused_lui;
  assign unused_lui = Lui0 | Lui1;

  always_comb begin
    ext = lat_ctrl ? {{PAD{1'b0}}, lat_imm} : {{PAD{lat_imm[IMM_W-1]}}, lat_imm};
  end
`endif

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state    <= IDLE;
      pri      <= 1'b0;
      lat_imm  <= '0;
      lat_ctrl <= 1'b0;
      lat_id   <= 1'b0;
      Ack0     <= 1'b0;
      Ack1     <= 1'b0;
      BusImm   <= '0;
      Valid    <= 1'b0;
      Id       <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      Ack0 <= 1'b0;
      Ack1 <= 1'b0;
      case (state)
        EXT: begin
          BusImm <= ext;
          Valid  <= 1'b1;
          Id     <= lat_id;
          state  <= RESP;
        end
        RESP: begin
          if (Ready) begin
            Valid <= 1'b0;
            pri   <= ~Id;
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        IDLE: ;
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
      if (do_grant) begin
        lat_imm  <= win ? Imm1 : Imm0;
        lat_ctrl <= win ? Ctrl1 : Ctrl0;
        lat_id   <= win;
        Ack0     <= ~win;
        Ack1     <= win;
        state    <= EXT;
        Busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_sched.sv
// Bench for imm_ext_sched: vector table through per-port scoreboards, plus arbitration, stall and reset sequences.
module tb_imm_ext_sched;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic [15:0] Imm0 = '0, Imm1 = '0;
  logic        Ctrl0 = 1'b0, Ctrl1 = 1'b0, Lui0 = 1'b0, Lui1 = 1'b0;
  logic        Ack0, Ack1, Valid, Id, Busy;
  logic [31:0] BusImm;
  logic        Ready = 1'b1;

  imm_ext_sched dut (
    .CLK(CLK), .Reset_L(Reset_L), .Req0(Req0), .Req1(Req1),
    .Imm0(Imm0), .Imm1(Imm1), .Ctrl0(Ctrl0), .Ctrl1(Ctrl1),
    .Lui0(Lui0), .Lui1(Lui1), .Ack0(Ack0), .Ack1(Ack1),
    .BusImm(BusImm), .Valid(Valid), .Id(Id), .Ready(Ready), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        p;
    logic [15:0] imm;
    logic        c;
    logic        l;
    logic [31:0] exp;
  } vec_t;

`ifdef IMM_EXT_LUI_EN
  localparam logic [31:0] EXP_1234 = 32'h12340000;
  localparam logic [31:0] EXP_ABCD = 32'hABCD0000;
`else
  localparam logic [31:0] EXP_1234 = 32'h00001234;
  localparam logic [31:0] EXP_ABCD = 32'h0000ABCD;
`endif

  vec_t        vecs [8];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int          ack_log [$];
  int          hs_log [$];
  int          cyc = 0;
  int          pass = 0;
  int          total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (Ack0 || Ack1) begin
        chk("single_ack", {31'd0, Ack0 & Ack1}, 32'd0);
        chk("ack_in_ext", {30'd0, Valid, Busy}, 32'd1);
        ack_log.push_back(Ack1 ? 1 : 0);
      end
      if (Valid && Ready) begin
        hs_log.push_back(cyc);
        if ((Id ? q1.size() : q0.size()) == 0) begin
          total++;
          $display("FAIL unexpected_result: id %0d data %h with empty scoreboard", Id, BusImm);
        end else begin
          e = Id ? q1.pop_front() : q0.pop_front();
          chk(Id ? "result_p1" : "result_p0", BusImm, e);
        end
      end
    end
  endtask

  task automatic issue(input logic p, input logic [15:0] imm, input logic c, input logic l,
                       input logic [31:0] exp);
    logic seen;
    if (!p) begin
      Imm0 = imm; Ctrl0 = c; Lui0 = l; Req0 = 1'b1; q0.push_back(exp);
    end else begin
      Imm1 = imm; Ctrl1 = c; Lui1 = l; Req1 = 1'b1; q1.push_back(exp);
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK);
      seen = p ? Ack1 : Ack0;
    end
    if (!seen) begin
      total++;
      $display("FAIL ack_timeout: port %0d got no ack, expected one within 60 cycles", p);
    end
    @(posedge CLK); #1;
    if (!p) Req0 = 1'b0; else Req1 = 1'b0;
    chk("ack_one_cycle", {31'd0, p ? Ack1 : Ack0}, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q0.size() + q1.size()) != 0; i++) @(negedge CLK);
    chk("drain_empty", q0.size() + q1.size(), 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    logic bad;
    vecs[0] = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 32'hFFFFFFFF};
    vecs[1] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 32'h0000FFFF};
    vecs[2] = '{1'b1, 16'h8000, 1'b0, 1'b0, 32'hFFFF8000};
    vecs[3] = '{1'b1, 16'h7FFF, 1'b0, 1'b0, 32'h00007FFF};
    vecs[4] = '{1'b0, 16'h8000, 1'b1, 1'b0, 32'h00008000};
    vecs[5] = '{1'b0, 16'h1234, 1'b0, 1'b1, EXP_1234};
    vecs[6] = '{1'b1, 16'h0001, 1'b0, 1'b0, 32'h00000001};
    vecs[7] = '{1'b1, 16'hABCD, 1'b1, 1'b1, EXP_ABCD};

    #2;
    chk("reset_outs", {BusImm[0], Ack0, Ack1, Valid, Id, Busy}, 32'd0);
    chk("reset_bus", BusImm, 32'd0);
    @(posedge CLK); #1;
    Reset_L = 1'b1;
    fork monitor(); join_none

    foreach (vecs[i]) issue(vecs[i].p, vecs[i].imm, vecs[i].c, vecs[i].l, vecs[i].exp);
    drain();

    // Round-robin from a fresh pointer with both ports always requesting.
    Reset_L = 1'b0;
    @(posedge CLK); #1;
    Reset_L = 1'b1;
    ack_log.delete();
    hs_log.delete();
    fork
      begin
        issue(1'b0, 16'h0011, 1'b0, 1'b0, 32'h00000011);
        issue(1'b0, 16'h8022, 1'b0, 1'b0, 32'hFFFF8022);
      end
      begin
        issue(1'b1, 16'h0033, 1'b1, 1'b0, 32'h00000033);
        issue(1'b1, 16'hF044, 1'b1, 1'b0, 32'h0000F044);
      end
    join
    drain();
    chk("rr_count", ack_log.size(), 32'd4);
    if (ack_log.size() == 4)
      chk("rr_order", {28'd0, ack_log[0][0], ack_log[1][0], ack_log[2][0], ack_log[3][0]}, 32'b0101);
    chk("rr_results", hs_log.size(), 32'd4);
    for (int i = 1; i < hs_log.size(); i++) chk("rr_spacing", hs_log[i] - hs_log[i-1], 32'd2);

    // Consumer stall with a pending request on port 1.
    Ready = 1'b0;
    issue(1'b0, 16'h8001, 1'b0, 1'b0, 32'hFFFF8001);
    chk("latency_valid", {31'd0, Valid}, 32'd1);
    fork
      issue(1'b1, 16'h00F0, 1'b0, 1'b0, 32'h000000F0);
      begin
        bad = 1'b0;
        repeat (5) begin
          @(negedge CLK);
          if (!(Valid === 1'b1 && Id === 1'b0 && BusImm === 32'hFFFF8001 && Ack1 === 1'b0)) bad = 1'b1;
        end
        chk("stall_hold", {31'd0, bad}, 32'd0);
        @(posedge CLK); #1;
        Ready = 1'b1;
        @(posedge CLK); #1;
        chk("grant_on_release", {31'd0, Ack1}, 32'd1);
      end
    join
    drain();

    // Asynchronous reset while the extender is working.
    Imm0 = 16'h5555; Ctrl0 = 1'b0; Req0 = 1'b1;
    @(posedge CLK); #1;
    chk("ext_state", {30'd0, Ack0, Busy}, 32'd3);
    #2;
    Reset_L = 1'b0;
    #1;
    chk("async_reset_outs", {27'd0, Ack0, Ack1, Valid, Id, Busy}, 32'd0);
    chk("async_reset_bus", BusImm, 32'd0);
    Req0 = 1'b0;
    @(posedge CLK); #1;
    Reset_L = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      if (Valid !== 1'b0) bad = 1'b1;
    end
    chk("idle_after_reset", {31'd0, bad}, 32'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
